// File: rtl/sigma_16p_split.sv
// Frame source for the 16-sample accumulator path: splits a 12-bit total into a
// 16-sample frame of 8-bit values whose sum equals the (clamped) total.
module sigma_16p_split #(
  parameter int unsigned GAP = 0
) (
  input  logic        clk,
  input  logic        res,
  input  logic [11:0] sum_in,
  input  logic        sum_valid,
  output logic        sum_ready,
  output logic [7:0]  data_out,
  output logic        data_vld,
  output logic        syn_out,
  output logic        busy,
  output logic        sat
);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  localparam logic [11:0] MaxTotal = 12'd4080;
  localparam bit          HasGap   = (GAP != 0);
  localparam logic [7:0]  GapInit  = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [7:0]  base_q;
  logic [3:0]  rem_q;
  logic [7:0]  gap_cnt_q;
  logic [7:0]  data_q;
  logic        vld_q;
  logic        syn_q;
  logic        sat_q;

  logic [11:0] total_clamped;
  logic        frame_end;
  logic        gap_end;
  logic        accept;
  logic [3:0]  next_idx;
  logic [7:0]  next_sample;
  logic [7:0]  first_sample;

  always_comb begin
    total_clamped = (sum_in > MaxTotal) ? MaxTotal : sum_in;
    frame_end     = (state_q == StSend) && (cnt_q == 4'd15);
    gap_end       = (state_q == StGap) && (gap_cnt_q == 8'd0);
    // Ready one cycle early on the last SEND/GAP cycle so frames can abut.
    sum_ready     = (state_q == StIdle) || (frame_end && !HasGap) || gap_end;
    accept        = sum_valid && sum_ready;
    next_idx      = cnt_q + 4'd1;
    next_sample   = base_q + {7'd0, (next_idx < rem_q)};
    first_sample  = total_clamped[11:4] + {7'd0, (total_clamped[3:0] != 4'd0)};
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      base_q    <= 8'd0;
      rem_q     <= 4'd0;
      gap_cnt_q <= 8'd0;
      data_q    <= 8'd0;
      vld_q     <= 1'b0;
      syn_q     <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      syn_q <= 1'b0;
      if (accept) begin
        state_q <= StSend;
        sat_q   <= (sum_in > MaxTotal);
        base_q  <= total_clamped[11:4];
        rem_q   <= total_clamped[3:0];
        cnt_q   <= 4'd0;
        data_q  <= first_sample;
        vld_q   <= 1'b1;
        syn_q   <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            data_q <= 8'd0;
            vld_q  <= 1'b0;
          end
          StSend: begin
            if (cnt_q == 4'd15) begin
              cnt_q     <= 4'd0;
              data_q    <= 8'd0;
              vld_q     <= 1'b0;
              gap_cnt_q <= GapInit;
              state_q   <= HasGap ? StGap : StIdle;
            end else begin
              cnt_q  <= next_idx;
              data_q <= next_sample;
            end
          end
          StGap: begin
            if (gap_cnt_q == 8'd0) begin
              state_q <= StIdle;
            end else begin
              gap_cnt_q <= gap_cnt_q - 8'd1;
            end
          end
          default: begin
            state_q <= StIdle;
            data_q  <= 8'd0;
            vld_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out = data_q;
  assign data_vld = vld_q;
  assign syn_out  = syn_q;
  assign sat      = sat_q;
  assign busy     = (state_q != StIdle);

endmodule
